// File: rtl/axis_window_generator_pkg.sv
// Shared helpers for axis_window_generator: derived counter width and
// parameter legality predicates used at elaboration.
package axis_window_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_KERNEL_SIZE     = 5;
    localparam int DEFAULT_MAX_IMAGE_WIDTH = 4096;

    function automatic int cw_for(input int max_w);
        return $clog2(max_w) + 1;
    endfunction

    function automatic bit kernel_ok(input int k);
        return (k >= 3) && (k <= 9) && (k % 2 == 1);
    endfunction

    function automatic bit width_ok(input int w);
        return (w > 1) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_window_generator_if.sv
// Pixel-in / window-out bundle for axis_window_generator.
// Coordinate outputs exist only with AXIS_WINDOW_COORD_OUT_EN defined.
interface axis_window_generator_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int CW          = 13
);
    logic [CW-1:0]         IMAGE_WIDTH;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_data_valid;
    logic                  i_start_of_frame;

    logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_window;
    logic                  o_window_valid;
    logic                  o_start_of_frame;
    logic                  o_end_of_line;
`ifdef AXIS_WINDOW_COORD_OUT_EN
    logic [CW-1:0]         o_center_col;
    logic [CW-1:0]         o_center_row;
`endif

    modport slave (
        input  IMAGE_WIDTH, i_data, i_data_valid, i_start_of_frame,
        output o_window, o_window_valid, o_start_of_frame, o_end_of_line
`ifdef AXIS_WINDOW_COORD_OUT_EN
        , output o_center_col, o_center_row
`endif
    );

    modport master (
        output IMAGE_WIDTH, i_data, i_data_valid, i_start_of_frame,
        input  o_window, o_window_valid, o_start_of_frame, o_end_of_line
`ifdef AXIS_WINDOW_COORD_OUT_EN
        , input o_center_col, o_center_row
`endif
    );

endinterface

// File: rtl/axis_window_generator_line_buffer_ram.sv
// One line of pixel history: async read, sync write at the same column,
// so the old value is read out in the cycle it is overwritten.
module line_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4096,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/axis_window_generator.sv
// KERNEL_SIZE x KERNEL_SIZE sliding window over a raster pixel stream.
// Optional centre-coordinate outputs: define AXIS_WINDOW_COORD_OUT_EN.
module axis_window_generator
    import axis_window_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_SIZE     = DEFAULT_KERNEL_SIZE,
    parameter int MAX_IMAGE_WIDTH = DEFAULT_MAX_IMAGE_WIDTH,
    parameter int CW              = cw_for(MAX_IMAGE_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_aresetn,
    axis_window_generator_if.slave  bus
);

    localparam int K  = KERNEL_SIZE;
    localparam int AW = $clog2(MAX_IMAGE_WIDTH);
    typedef logic [DATA_WIDTH-1:0] pixel_t;

    if (!kernel_ok(K)) begin : g_bad_kernel
        $error("KERNEL_SIZE must be odd and within 3..9");
    end
    if (!width_ok(MAX_IMAGE_WIDTH)) begin : g_bad_width
        $error("MAX_IMAGE_WIDTH must be a power of two");
    end

    logic [CW-1:0] col, row, width;
    logic [CW-1:0] width_in, cur_width, pix_col, pix_row;
    logic [CW-1:0] next_col, next_row;
    logic          acc, sof_px, last_col, win_valid_d;

    assign acc      = bus.i_data_valid;
    assign sof_px   = acc & bus.i_start_of_frame;
    assign width_in = (bus.IMAGE_WIDTH > CW'(MAX_IMAGE_WIDTH)) ? CW'(MAX_IMAGE_WIDTH)
                                                               : bus.IMAGE_WIDTH;

    // Counters hold the position of the next pixel; SOF overrides them.
    assign cur_width = sof_px ? width_in : width;
    assign pix_col   = sof_px ? '0 : col;
    assign pix_row   = sof_px ? '0 : row;
    assign last_col  = (pix_col == cur_width - CW'(1));
    assign next_col  = last_col ? '0 : pix_col + CW'(1);
    assign next_row  = !last_col ? pix_row :
                       (&pix_row) ? pix_row : pix_row + CW'(1);

    assign win_valid_d = acc && (pix_row >= CW'(K - 1)) && (pix_col >= CW'(K - 1));

    // vec[r] is the new window column: vec[0] live pixel, vec[r] r lines older.
    pixel_t vec [K];
    pixel_t rd  [K-1];

    assign vec[0] = bus.i_data;

    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        line_buffer_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_IMAGE_WIDTH)
        ) u_lb (
            .clk   (i_clk),
            .we    (acc),
            .addr  (pix_col[AW-1:0]),
            .wdata (vec[i]),
            .rdata (rd[i])
        );
        assign vec[i+1] = rd[i];
    end

    logic [0:K-1][0:K-1][DATA_WIDTH-1:0] win;
    logic win_valid, sof_q, eol_q;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            win       <= '0;
            win_valid <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            col       <= '0;
            row       <= '0;
            width     <= CW'(MAX_IMAGE_WIDTH);
        end else begin
            win_valid <= win_valid_d;
            sof_q     <= sof_px;
            eol_q     <= acc & last_col;
            if (sof_px) width <= width_in;
            if (acc) begin
                col <= next_col;
                row <= next_row;
                for (int r = 0; r < K; r++) begin
                    win[r][0] <= vec[r];
                    for (int c = 1; c < K; c++) win[r][c] <= win[r][c-1];
                end
            end
        end
    end

    assign bus.o_window         = win;
    assign bus.o_window_valid   = win_valid;
    assign bus.o_start_of_frame = sof_q;
    assign bus.o_end_of_line    = eol_q;

`ifdef AXIS_WINDOW_COORD_OUT_EN
    logic [CW-1:0] ccol, crow;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            ccol <= '0;
            crow <= '0;
        end else if (win_valid_d) begin
            ccol <= pix_col - CW'((K - 1) / 2);
            crow <= pix_row - CW'((K - 1) / 2);
        end
    end

    assign bus.o_center_col = ccol;
    assign bus.o_center_row = crow;
`endif

endmodule

// File: tb/tb_axis_window_generator.sv
// Scoreboard bench for axis_window_generator (K=5): stimulus pushes expected
// outputs per pixel, a negedge monitor pops and compares them.
module tb_axis_window_generator;

    localparam int DW = 8;
    localparam int K  = 5;
    localparam int CW = 13;

    typedef logic [0:K-1][0:K-1][DW-1:0] win_t;
    typedef struct {
        logic vld, eol, sof;
        win_t win;
        int   ccol, crow;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_window_generator_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .CW(CW)) bus ();

    axis_window_generator #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_IMAGE_WIDTH(4096)
    ) dut (
        .i_clk     (clk),
        .i_aresetn (rst_n),
        .bus       (bus)
    );

    int n_chk = 0, n_fail = 0;
    exp_t q[$];
    int frame [0:1023];
    int m_col = 0, m_row = 0, m_w = 4096, cur_idx = 0;

    int   valid_cnt = 0, eol_cnt = 0, first_idx = -1;
    win_t first_win;
    logic acc_seen = 1'b1;
    int   idx_seen = 0;
    win_t prev_win;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: track position and frame contents, predict outputs.
    task automatic send(input logic [DW-1:0] d, input bit s, input int idx);
        exp_t e;
        int pc, pr;
        if (s) begin
            m_w = (bus.IMAGE_WIDTH > 4096) ? 4096 : int'(bus.IMAGE_WIDTH);
            m_col = 0; m_row = 0;
        end
        pc = m_col; pr = m_row;
        frame[pr * m_w + pc] = int'(d);
        e.vld = (pr >= K - 1) && (pc >= K - 1);
        e.eol = (pc == m_w - 1);
        e.sof = s;
        e.win = '0;
        e.ccol = pc - (K - 1) / 2;
        e.crow = pr - (K - 1) / 2;
        if (e.vld)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    e.win[r][c] = DW'(frame[(pr - r) * m_w + (pc - c)]);
        if (e.vld || e.eol || e.sof) q.push_back(e);
        if (pc == m_w - 1) begin m_col = 0; m_row++; end
        else m_col++;
        cur_idx = idx;
        bus.i_data = d;
        bus.i_start_of_frame = s;
        bus.i_data_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_data_valid = 1'b0;
        bus.i_start_of_frame = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.i_data_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_stats();
        valid_cnt = 0; eol_cnt = 0; first_idx = -1;
    endtask

    task automatic frame_ramp(input int w, input int npix, input int base, input bit gaps);
        bus.IMAGE_WIDTH = CW'(w);
        for (int i = 0; i < npix; i++) begin
            send(DW'(base + i), i == 0, i);
            if (gaps) idle(1);
        end
        idle(3);
    endtask

    always @(posedge clk) begin
        acc_seen <= bus.i_data_valid;
        idx_seen <= cur_idx;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!acc_seen) check("hold", bus.o_window, prev_win);
            if (bus.o_window_valid || bus.o_end_of_line || bus.o_start_of_frame) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: valid=%0b eol=%0b sof=%0b with nothing expected",
                             bus.o_window_valid, bus.o_end_of_line, bus.o_start_of_frame);
                end else begin
                    e = q.pop_front();
                    check("flags", {bus.o_window_valid, bus.o_end_of_line, bus.o_start_of_frame},
                          {e.vld, e.eol, e.sof});
                    if (e.vld) begin
                        check("window", bus.o_window, e.win);
`ifdef AXIS_WINDOW_COORD_OUT_EN
                        check("center_col", bus.o_center_col, CW'(e.ccol));
                        check("center_row", bus.o_center_row, CW'(e.crow));
`endif
                    end
                end
                if (bus.o_window_valid) begin
                    if (first_idx < 0) begin first_idx = idx_seen; first_win = bus.o_window; end
                    valid_cnt++;
                end
                if (bus.o_end_of_line) eol_cnt++;
            end
        end
        prev_win = bus.o_window;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t hw;
        bus.IMAGE_WIDTH = CW'(10);
        bus.i_data = '0;
        bus.i_data_valid = 1'b0;
        bus.i_start_of_frame = 1'b0;
        #23;
        check("rst_window", bus.o_window, '0);
        check("rst_flags", {bus.o_window_valid, bus.o_end_of_line, bus.o_start_of_frame}, 3'b000);
        @(negedge clk); rst_n = 1'b1;
        idle(2);

        // Continuous ramp, width 10
        clear_stats();
        frame_ramp(10, 100, 0, 1'b0);
        check("t1_valid_cnt", valid_cnt, 36);
        check("t1_eol_cnt", eol_cnt, 10);
        check("t1_first_idx", first_idx, 44);
        for (int c = 0; c < K; c++) begin
            hw[0][c] = DW'(44 - c);
            hw[4][c] = DW'(4 - c);
        end
        check("t1_first_row0", first_win[0], hw[0]);
        check("t1_first_row4", first_win[4], hw[4]);

        // Same stream with 1010 valid pattern
        clear_stats();
        frame_ramp(10, 100, 0, 1'b1);
        check("t2_valid_cnt", valid_cnt, 36);
        check("t2_eol_cnt", eol_cnt, 10);
        check("t2_first_idx", first_idx, 44);

        // Frame A width 10, then frame B width 8 without reset
        frame_ramp(10, 100, 0, 1'b0);
        clear_stats();
        frame_ramp(8, 64, 128, 1'b0);
        check("t3_valid_cnt", valid_cnt, 16);
        check("t3_first_idx", first_idx, 36);
        check("t3_first_00", first_win[0][0], 8'd164);
        check("t3_first_44", first_win[4][4], 8'd128);

        // Width below kernel size
        clear_stats();
        frame_ramp(4, 40, 0, 1'b0);
        check("t4_valid_cnt", valid_cnt, 0);
        check("t4_eol_cnt", eol_cnt, 10);

        // SOF in mid-line restarts the counters
        bus.IMAGE_WIDTH = CW'(10);
        for (int i = 0; i < 15; i++) send(DW'(200 + i), i == 0, i);
        clear_stats();
        frame_ramp(10, 100, 0, 1'b0);
        check("t5_valid_cnt", valid_cnt, 36);
        check("t5_first_idx", first_idx, 44);

        // Asynchronous reset at pixel 27, then restart
        bus.IMAGE_WIDTH = CW'(10);
        for (int i = 0; i < 27; i++) send(DW'(50 + i), i == 0, i);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_window", bus.o_window, '0);
        check("t6_rst_flags", {bus.o_window_valid, bus.o_end_of_line, bus.o_start_of_frame}, 3'b000);
        check("t6_queue_drained", q.size(), 0);
        m_col = 0; m_row = 0; m_w = 4096;
        idle(2);
        @(negedge clk); rst_n = 1'b1;
        idle(1);
        clear_stats();
        frame_ramp(10, 100, 0, 1'b0);
        check("t6_valid_cnt", valid_cnt, 36);
        check("t6_first_idx", first_idx, 44);
        check("t6_first_row0", first_win[0], hw[0]);

        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_window_generator.md
Name: axis_window_generator

Overview:
- Parametrised successor to the 5x5 pixel receiver: builds a KERNEL_SIZE x KERNEL_SIZE sliding window from a raster pixel stream for the downstream filter (median, convolution).
- Line buffers are internal circular RAMs indexed by column, with no vendor FIFO IP and no FIFO-latency tuning.
- Runtime image width; explicit window-valid qualification, so edge and warm-up windows are never flagged valid.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- KERNEL_SIZE, 5, window side; legal 3..9.
- MAX_IMAGE_WIDTH, 4096, line buffer depth; power of two.
- CW, $clog2(MAX_IMAGE_WIDTH)+1, column/row counter width (derived; do not override).

Ports:
- i_clk  in  1  clock.
- i_aresetn  in  1  reset, asynchronous, active-low.
- IMAGE_WIDTH  in  CW  active line length in pixels; sampled on the SOF pixel.
- i_data  in  DATA_WIDTH  pixel.
- i_data_valid  in  1  pixel accepted this cycle; no backpressure.
- i_start_of_frame  in  1  qualifies the first pixel of a frame; only meaningful with i_data_valid.
- o_window  out  [0:K-1][0:K-1] x DATA_WIDTH  window: [r][c], r=0 newest row, c=0 newest column.
- o_window_valid  out  1  window fully inside the image; one cycle per qualifying pixel.
- o_start_of_frame  out  1  registered i_start_of_frame & i_data_valid.
- o_end_of_line  out  1  registered "accepted pixel was last column".

Behaviour:
- Reset: o_window all zero; o_window_valid, o_start_of_frame, o_end_of_line = 0. Column and row counters = 0. Width register = MAX_IMAGE_WIDTH. RAM contents are not cleared.
- Width register: loaded on an SOF pixel with min(IMAGE_WIDTH, MAX_IMAGE_WIDTH). Mid-frame IMAGE_WIDTH changes are ignored.
- Position of each accepted pixel:
  - SOF pixel: (col,row) = (0,0), irrespective of the counters.
  - Otherwise: col increments; at col = width-1 it wraps to 0 and row increments. Row saturates at all-ones.
- Line buffers: K-1 RAMs lb[0..K-2], depth MAX_IMAGE_WIDTH, asynchronous read, synchronous write. On an accepted pixel at column c:
  - The new column vector is {i_data, lb[0][c], ..., lb[K-2][c]}.
  - Write lb[0][c] <= i_data and lb[i][c] <= lb[i-1][c] (read-before-write, same cycle).
- Window shift: on an accepted pixel, o_window[r][0] <= vector[r] and o_window[r][c] <= o_window[r][c-1]. With no accepted pixel, o_window holds.
- Latency: 1 cycle from accepted pixel to updated o_window, o_window_valid, o_end_of_line, o_start_of_frame.
- o_window_valid = accepted & row >= K-1 & col >= K-1, evaluated on the accepted pixel's position.
- Boundary conditions:
  - Windows straddling a line wrap (col < K-1) are never valid.
  - Stale RAM data from a previous frame is never flagged valid, because of the row gate.
  - Width < KERNEL_SIZE: o_window_valid never asserts; counters still operate.
  - Gaps in i_data_valid are allowed anywhere; state holds.
  - SOF mid-line: counters restart at (0,0) and no flush is required.
  - Asynchronous reset mid-frame: everything returns to the reset state and the next frame must start with SOF. Before the first SOF, width = MAX_IMAGE_WIDTH.
- Pixels per frame are unbounded; height is implied by SOF spacing.

Optional Feature:
- Macro: AXIS_WINDOW_COORD_OUT_EN.
- Defined: adds outputs o_center_col and o_center_row (CW bits each), registered with o_window_valid. Values are col-(K-1)/2 and row-(K-1)/2 of the window centre; they are meaningful only while o_window_valid = 1 and hold otherwise.
- Undefined: the ports do not exist and no extra logic is built.

Decomposition:
- Package axis_window_pkg:
  - Parameter legality checks (KERNEL_SIZE odd 3..9, MAX_IMAGE_WIDTH a power of two).
  - Function clog2-derived CW.
  - typedef pixel_t, parameterised on DATA_WIDTH via a localparam in the module.
- Sub-module line_buffer_ram: DATA_WIDTH x MAX_IMAGE_WIDTH, one write port, one asynchronous read port at the same address, read-before-write. The top instantiates K-1 of them in a generate loop.

Test Plan:
- Width 10, K=5, ramp pixels 0..99 with SOF on pixel 0 and valid continuous.
  - Expect the first o_window_valid the cycle after pixel 44.
  - o_window[0] = {44,43,42,41,40}; o_window[4] = {4,3,2,1,0}.
  - 36 valid pulses per frame; o_end_of_line after pixels 9, 19, ..., 99.
- Same stimulus with i_data_valid toggling 1010...: identical window sequence and valid count, with o_window holding during gaps.
- Frame A (width 10) then frame B (width 8, SOF) without reset.
  - No valid until B pixel 4*8+4 = 36.
  - B windows contain only B data; 16 valid pulses in B.
- IMAGE_WIDTH = 4 (< K=5), 40 pixels: o_window_valid never asserts; o_end_of_line every 4th pixel.
- Reset asserted at pixel 27 of a width-10 frame.
  - Outputs zero asynchronously.
  - Restart with SOF: first valid again after pixel 44, with correct data.
- AXIS_WINDOW_COORD_OUT_EN defined, width 10: the first valid has centre (2,2); the last has (7,7).
